intr_gen_multi: RTL and testbench
=================================

Name: intr_gen_multi

Overview:
- Parametrised multi-channel successor to the single-button interrupt FSM.
- Each of NUM_CH press inputs is synchronised, then qualified by a hold-time delay.
- A qualified press latches a pending bit. A fixed-priority arbiter drives one interrupt line plus the granted channel ID to the CPU's interrupt input.
- Each channel re-arms only after its press input is released.

Parameters:
- NUM_CH, 4, number of press channels (1..16).
- DELAY_CYCLES, 90908, cycles press must stay high before the channel becomes pending (≥2).
- PULSE_CYCLES, 6, interrupt high time in pulse mode (≥1).
- DBG_CH, 0, channel whose state is shown on statePMOD.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- press  in  NUM_CH  raw asynchronous press inputs.
- mask  in  NUM_CH  1 = channel may be granted; masked channels still become pending.
- ack  in  1  CPU acknowledge; used only with INTR_ACK_HANDSHAKE_EN.
- interrupt  out  1  interrupt request to the CPU.
- intr_id  out  max(1,$clog2(NUM_CH))  index of the granted channel; valid while interrupt=1.
- pending  out  NUM_CH  per-channel pending flags.
- statePMOD  out  4  one-hot state of channel DBG_CH: IDLE=0001, QUAL=0010, PEND=0100, RELOAD=1000.

Behaviour:
- Reset (async, rst_n=0): all synchroniser flops=0, all channels IDLE, counters=0, pending=0, interrupt=0, intr_id=0, statePMOD=0001. Outputs change immediately, without waiting for a clock. Reset mid-qualify or mid-pulse aborts with no interrupt.
- Synchroniser: press passes through 2 flops per channel to give press_s.
- Channel FSM, one per channel. Counter width $clog2(DELAY_CYCLES).
  - IDLE: cnt=0. If press_s=1, go to QUAL.
  - QUAL: if press_s=0, go to IDLE and clear cnt (bounce rejected). Else if cnt==DELAY_CYCLES-1, go to PEND. Else cnt++. The counter never wraps.
  - PEND: pending[i]=1. On grant, go to RELOAD and clear pending[i] on the same edge.
  - RELOAD: stay while press_s=1. Go to IDLE when press_s=0. Holding the button never produces a second interrupt.
  - Illegal encodings go to IDLE on the next edge.
- Arbiter FSM:
  - A_IDLE: candidate set = pending & mask. If it is nonzero, the lowest index wins. On that edge: interrupt←1, intr_id←winner, grant pulse to the winner, go to A_ASSERT.
  - A_ASSERT: hold interrupt and intr_id. Exit condition depends on mode (see Optional Feature). On exit: interrupt←0, go to A_GAP.
  - A_GAP: one cycle with interrupt=0, then go to A_IDLE. This guarantees a visible edge between back-to-back interrupts.
- Latency: raw press first sampled high at edge e0 gives interrupt=1 after edge e0+DELAY_CYCLES+3, provided the arbiter is idle and the channel is unmasked.
- Simultaneous qualifications: all affected channels go PEND. They are served in index order, each separated by the A_GAP cycle.
- Mask cleared while a channel is PEND: the channel stays pending and is granted once unmasked.
- Mask changes during A_ASSERT do not affect the current interrupt.
- A press on a channel in RELOAD or PEND does not restart or duplicate its request.

Optional Feature:
- Macro: INTR_ACK_HANDSHAKE_EN.
- Defined (handshake mode): A_ASSERT holds interrupt until ack is sampled high, with no timeout. ack seen in A_IDLE or A_GAP is ignored. The pulse counter is not built.
- Undefined (pulse mode): A_ASSERT lasts exactly PULSE_CYCLES cycles, counted by a $clog2(PULSE_CYCLES+1)-bit counter. The ack input is ignored.

Test Plan:
- NUM_CH=4, DELAY_CYCLES=4, PULSE_CYCLES=6, pulse mode. press[0] rises before edge e0 and is held → interrupt=1 after edge e0+7 for exactly 6 cycles, intr_id=0. statePMOD shows 0001→0010→0100→1000. No second interrupt while press[0] stays high. Release → 0001.
- Bounce: press[2] high for 3 cycles, low, then high for 3 cycles → no interrupt, pending=0, channel returns to IDLE each time.
- press[1] and press[3] rise on the same edge, both held → pending=1010. First interrupt has intr_id=1. After the 6-cycle pulse and 1 gap cycle, second interrupt has intr_id=3.
- mask=1110, press[0] qualifies → pending[0]=1, interrupt stays 0. Set mask[0]=1 → interrupt after 1 edge, intr_id=0.
- INTR_ACK_HANDSHAKE_EN defined: interrupt stays high 50 cycles with ack=0. ack pulsed 1 cycle → interrupt=0 on next edge. ack in idle → no effect.
- rst_n driven 0 asynchronously mid-pulse (cycle 3 of 6) → interrupt=0 and pending=0 immediately. After release of reset with press held, the full DELAY_CYCLES is qualified again before the next interrupt.

Source files
------------

// File: rtl/intr_gen_multi.sv
// Multi-channel press-to-interrupt generator: synchronise, qualify, latch pending, fixed-priority grant.
// Optional macro INTR_ACK_HANDSHAKE_EN: interrupt held until ack instead of a fixed-length pulse.
module intr_gen_multi #(
  parameter int NUM_CH       = 4,
  parameter int DELAY_CYCLES = 90908,
  parameter int PULSE_CYCLES = 6,
  parameter int DBG_CH       = 0,
  localparam int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] press,
  input  logic [NUM_CH-1:0] mask,
  input  logic              ack,
  output logic              interrupt,
  output logic [ID_W-1:0]   intr_id,
  output logic [NUM_CH-1:0] pending,
  output logic [3:0]        statePMOD
);

  localparam int CNT_W = $clog2(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    CH_IDLE   = 4'b0001,
    CH_QUAL   = 4'b0010,
    CH_PEND   = 4'b0100,
    CH_RELOAD = 4'b1000
  } chState_e;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_ASSERT = 2'd1,
    A_GAP    = 2'd2
  } arbState_e;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  chState_e          chState_q [NUM_CH];
  chState_e          chState_d [NUM_CH];
  logic [CNT_W-1:0]  chCnt_q [NUM_CH];
  logic [CNT_W-1:0]  chCnt_d [NUM_CH];
  arbState_e         arbState_q, arbState_d;
  logic              interrupt_q, interrupt_d;
  logic [ID_W-1:0]   intrId_q, intrId_d;
  logic [NUM_CH-1:0] cand, firstHot, grant;
  logic [ID_W-1:0]   winner;
  logic              found;

`ifndef INTR_ACK_HANDSHAKE_EN
  localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              unused_ack;
  assign unused_ack = ack;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        chState_q[i] <= CH_IDLE;
        chCnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= press;
      sync2_q <= sync1_q;
      for (int i = 0; i < NUM_CH; i++) begin
        chState_q[i] <= chState_d[i];
        chCnt_q[i]   <= chCnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) pending[i] = (chState_q[i] == CH_PEND);
  end

  // The qualify counter only holds a nonzero value while in QUAL, so every exit clears it.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      chState_d[i] = chState_q[i];
      chCnt_d[i]   = '0;
      case (chState_q[i])
        CH_IDLE:   if (sync2_q[i]) chState_d[i] = CH_QUAL;
        CH_QUAL: begin
          if (!sync2_q[i])                 chState_d[i] = CH_IDLE;
          else if (chCnt_q[i] == CNT_LAST) chState_d[i] = CH_PEND;
          else                             chCnt_d[i]   = chCnt_q[i] + CNT_W'(1);
        end
        CH_PEND:   if (grant[i]) chState_d[i] = CH_RELOAD;
        CH_RELOAD: if (!sync2_q[i]) chState_d[i] = CH_IDLE;
        default:   chState_d[i] = CH_IDLE;
      endcase
    end
  end

  always_comb begin
    cand     = pending & mask;
    winner   = '0;
    firstHot = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand[i] && !found) begin
        found       = 1'b1;
        winner      = ID_W'(i);
        firstHot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arbState_q  <= A_IDLE;
      interrupt_q <= 1'b0;
      intrId_q    <= '0;
`ifndef INTR_ACK_HANDSHAKE_EN
      pcnt_q      <= '0;
`endif
    end else begin
      arbState_q  <= arbState_d;
      interrupt_q <= interrupt_d;
      intrId_q    <= intrId_d;
`ifndef INTR_ACK_HANDSHAKE_EN
      pcnt_q      <= pcnt_d;
`endif
    end
  end

  // Grant is issued only from A_IDLE, so mask changes during an assertion cannot disturb it.
  always_comb begin
    arbState_d  = arbState_q;
    interrupt_d = interrupt_q;
    intrId_d    = intrId_q;
    grant       = '0;
`ifndef INTR_ACK_HANDSHAKE_EN
    pcnt_d      = pcnt_q;
`endif
    case (arbState_q)
      A_IDLE: begin
        if (found) begin
          grant       = firstHot;
          interrupt_d = 1'b1;
          intrId_d    = winner;
          arbState_d  = A_ASSERT;
`ifndef INTR_ACK_HANDSHAKE_EN
          pcnt_d      = '0;
`endif
        end
      end
      A_ASSERT: begin
`ifdef INTR_ACK_HANDSHAKE_EN
        if (ack) begin
          interrupt_d = 1'b0;
          arbState_d  = A_GAP;
        end
`else
        if (pcnt_q == PCNT_LAST) begin
          interrupt_d = 1'b0;
          arbState_d  = A_GAP;
          pcnt_d      = '0;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
`endif
      end
      A_GAP:   arbState_d = A_IDLE;
      default: begin
        arbState_d  = A_IDLE;
        interrupt_d = 1'b0;
      end
    endcase
  end

  assign interrupt = interrupt_q;
  assign intr_id   = intrId_q;
  assign statePMOD = chState_q[DBG_CH];

endmodule

// File: tb/tb_intr_gen_multi.sv
// Self-checking bench for intr_gen_multi (NUM_CH=4, DELAY_CYCLES=4, PULSE_CYCLES=6).
// Exercises pulse mode by default and handshake mode when INTR_ACK_HANDSHAKE_EN is defined.
module tb_intr_gen_multi;

  localparam int NUM_CH = 4;
  localparam int DELAY  = 4;
  localparam int PULSE  = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] press, mask;
  logic       ack;
  logic       interrupt;
  logic [1:0] intr_id;
  logic [3:0] pending, statePMOD;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    logic [3:0] press;
    logic       ack;
    logic       expInt;
    logic [3:0] expPend;
    logic [3:0] expState;
  } vec_t;

  vec_t vecs [19];

  intr_gen_multi #(
    .NUM_CH(NUM_CH), .DELAY_CYCLES(DELAY), .PULSE_CYCLES(PULSE), .DBG_CH(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .mask(mask), .ack(ack),
    .interrupt(interrupt), .intr_id(intr_id), .pending(pending), .statePMOD(statePMOD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] p, input logic [3:0] m, input logic a);
    press = p;
    mask  = m;
    ack   = a;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitRise(input int maxCyc, output int cnt);
    cnt = 0;
    while (!interrupt && cnt < maxCyc) begin
      tick();
      cnt++;
    end
    checkOutput("rise within bound", interrupt, 1);
  endtask

  // Called on the cycle the interrupt is first seen high; ends with it low.
  task automatic finishIntr();
`ifdef INTR_ACK_HANDSHAKE_EN
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("ack drops interrupt", interrupt, 0);
`else
    for (int k = 1; k < PULSE; k++) begin
      tick();
      checkOutput("pulse held", interrupt, 1);
    end
    tick();
    checkOutput("pulse ends", interrupt, 0);
`endif
  endtask

  task automatic settle();
    press = 4'b0000;
    ack   = 1'b0;
    repeat (8) tick();
    checkOutput("settle interrupt", interrupt, 0);
    checkOutput("settle pending", pending, 0);
    checkOutput("settle state", statePMOD, 4'b0001);
  endtask

  initial begin
    rst_n = 1'b0;
    press = 4'b0000;
    mask  = 4'b1111;
    ack   = 1'b0;
    repeat (2) tick();
    checkOutput("reset interrupt", interrupt, 0);
    checkOutput("reset intr_id", intr_id, 0);
    checkOutput("reset pending", pending, 0);
    checkOutput("reset state", statePMOD, 4'b0001);
    rst_n = 1'b1;

`ifndef INTR_ACK_HANDSHAKE_EN
    // Single press on channel 0, ack pulsed mid-interrupt to show it is ignored.
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001};
    vecs[1]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001};
    vecs[2]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0010};
    vecs[3]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0010};
    vecs[4]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0010};
    vecs[5]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0010};
    vecs[6]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0100};
    vecs[7]  = '{4'b0001, 1'b0, 1'b1, 4'b0000, 4'b1000};
    vecs[8]  = '{4'b0001, 1'b0, 1'b1, 4'b0000, 4'b1000};
    vecs[9]  = '{4'b0001, 1'b1, 1'b1, 4'b0000, 4'b1000};
    vecs[10] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 4'b1000};
    vecs[11] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 4'b1000};
    vecs[12] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 4'b1000};
    vecs[13] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b1000};
    vecs[14] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b1000};
    vecs[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1000};
    vecs[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1000};
    vecs[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001};
    vecs[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001};
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].press, 4'b1111, vecs[i].ack);
      checkOutput($sformatf("vec%0d interrupt", i), interrupt, vecs[i].expInt);
      checkOutput($sformatf("vec%0d pending", i), pending, vecs[i].expPend);
      checkOutput($sformatf("vec%0d state", i), statePMOD, vecs[i].expState);
      checkOutput($sformatf("vec%0d intr_id", i), intr_id, 0);
    end
`else
    applyStimulus(4'b0000, 4'b1111, 1'b1);
    checkOutput("ack in idle", interrupt, 0);
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    checkOutput("ack in idle after", interrupt, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0001, 4'b1111, 1'b0);
      checkOutput($sformatf("hs latency edge%0d", k), interrupt, (k == 7));
    end
    checkOutput("hs intr_id", intr_id, 0);
    for (int k = 0; k < 50; k++) begin
      tick();
      checkOutput("hs held without ack", interrupt, 1);
    end
    finishIntr();
`endif
    settle();

    // Bounce on channel 2: two 3-cycle bursts never reach the qualify length.
    for (int k = 0; k < 14; k++) begin
      applyStimulus((k < 3 || (k >= 6 && k < 9)) ? 4'b0100 : 4'b0000, 4'b1111, 1'b0);
      checkOutput($sformatf("bounce interrupt k%0d", k), interrupt, 0);
      checkOutput($sformatf("bounce pending k%0d", k), pending, 0);
    end

    // Channels 1 and 3 qualify together and are served in index order.
    for (int k = 0; k < 7; k++) applyStimulus(4'b1010, 4'b1111, 1'b0);
    checkOutput("simul pending", pending, 4'b1010);
    checkOutput("simul no interrupt yet", interrupt, 0);
    applyStimulus(4'b1010, 4'b1111, 1'b0);
    checkOutput("simul first interrupt", interrupt, 1);
    checkOutput("simul first id", intr_id, 1);
    checkOutput("simul pending after grant", pending, 4'b1000);
    finishIntr();
    waitRise(6, n);
    checkOutput("simul low gap seen", (n >= 1), 1);
    checkOutput("simul second id", intr_id, 3);
    checkOutput("simul pending cleared", pending, 0);
    finishIntr();
    settle();

    // Masked channel stays pending until its mask bit is set.
    for (int k = 0; k < 7; k++) applyStimulus(4'b0001, 4'b1110, 1'b0);
    checkOutput("mask pending", pending, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, 4'b1110, 1'b0);
      checkOutput("mask blocks interrupt", interrupt, 0);
      checkOutput("mask keeps pending", pending, 4'b0001);
    end
    applyStimulus(4'b0001, 4'b1111, 1'b0);
    checkOutput("unmask interrupt", interrupt, 1);
    checkOutput("unmask id", intr_id, 0);
    checkOutput("unmask pending cleared", pending, 0);
    finishIntr();
    mask = 4'b1111;
    settle();

    // Asynchronous reset in the third cycle of an interrupt, then full requalification.
    for (int k = 0; k < 8; k++) applyStimulus(4'b0001, 4'b1111, 1'b0);
    checkOutput("pre-reset interrupt", interrupt, 1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset interrupt", interrupt, 0);
    checkOutput("async reset pending", pending, 0);
    checkOutput("async reset state", statePMOD, 4'b0001);
    checkOutput("async reset intr_id", intr_id, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 6) checkOutput("requalify pending", pending, 4'b0001);
      checkOutput($sformatf("requalify interrupt edge%0d", k), interrupt, (k == 7));
    end
    finishIntr();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
